// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory unit.
//
// Handshake: a requester raises *_req with its address/data/we stable and
// holds all of them until the matching *_ack pulses for one cycle. *_q is
// valid in the ack cycle. The requester drops *_req in the cycle after the
// ack. A req still high when the arbiter is back in IDLE counts as a new
// request. On the memory side, mem_start stays high from grant until
// mem_busy has risen and then fallen. mem_q is valid once mem_busy is low
// again.
interface mem_arbiter_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic [DATA_W-1:0] f_q;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_data;
  logic              d_we;
  logic              d_ack;
  logic [DATA_W-1:0] d_q;
  logic              err;
  logic              mem_init_done;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;
  logic              mem_start;
  logic              mem_busy;
  logic [DATA_W-1:0] mem_q;

  // Arbiter's view of the bundle.
  modport slave (
    input  f_req, f_addr, d_req, d_addr, d_data, d_we,
    input  mem_init_done, mem_busy, mem_q,
    output f_ack, f_q, d_ack, d_q, err,
    output mem_address, mem_data, mem_we, mem_start
  );

  // View of the surrounding requesters and memory unit.
  modport master (
    output f_req, f_addr, d_req, d_addr, d_data, d_we,
    output mem_init_done, mem_busy, mem_q,
    input  f_ack, f_q, d_ack, d_q, err,
    input  mem_address, mem_data, mem_we, mem_start
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master (fetch / data) arbiter in front of the memory unit.
// Strict alternation when both masters request. A start/busy handshake runs
// toward memory. A watchdog aborts hung accesses with ERR_WORD and err.
module mem_arbiter #(
  parameter int                ADDR_W   = 27,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 1023,
  parameter logic [DATA_W-1:0] ERR_WORD = DATA_W'(32'hDEADBEEF)
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic [1:0]    state_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic M_FETCH = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_RISE = 2'd1,
    S_WAIT_FALL = 2'd2,
    S_RELEASE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;            // 0 = fetch, 1 = data
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              start_q, start_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              f_ack_q, f_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] f_q_q, f_q_d;
  logic [DATA_W-1:0] d_q_q, d_q_d;

  logic              timeout_hit;
  logic              done;
  logic              abort;
  logic              pick;
  logic [DATA_W-1:0] rdata;

  // The counter reaches TIMEOUT on this edge.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State register and every registered output; reset drops mem_start at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= M_FETCH;
      last_grant_q <= M_FETCH;
      addr_q       <= '0;
      data_q       <= '0;
      we_q         <= 1'b0;
      start_q      <= 1'b0;
      cnt_q        <= '0;
      f_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      err_q        <= 1'b0;
      f_q_q        <= '0;
      d_q_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      we_q         <= we_d;
      start_q      <= start_d;
      cnt_q        <= cnt_d;
      f_ack_q      <= f_ack_d;
      d_ack_q      <= d_ack_d;
      err_q        <= err_d;
      f_q_q        <= f_q_d;
      d_q_q        <= d_q_d;
    end
  end

  // Next-state logic: grant, wait for busy rise/fall (or the watchdog), release.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    data_d       = data_q;
    we_d         = we_q;
    start_d      = start_q;
    cnt_d        = cnt_q;
    f_q_d        = f_q_q;
    d_q_d        = d_q_q;
    f_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    err_d        = 1'b0;
    done         = 1'b0;
    abort        = 1'b0;
    pick         = M_FETCH;
    rdata        = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.mem_init_done && (bus.f_req || bus.d_req)) begin
          // Both requesting: whoever was not served last goes first.
          pick    = (bus.f_req && bus.d_req) ? ~last_grant_q : bus.d_req;
          grant_d = pick;
          addr_d  = pick ? bus.d_addr : bus.f_addr;
          data_d  = pick ? bus.d_data : '0;
          we_d    = pick & bus.d_we;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT_RISE;
        end
      end
      S_WAIT_RISE: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout_hit) begin
          done  = 1'b1;
          abort = 1'b1;
        end else if (bus.mem_busy) begin
          state_d = S_WAIT_FALL;
        end
      end
      S_WAIT_FALL: begin
        cnt_d = cnt_q + 1'b1;
        // A genuine completion on the last allowed cycle still wins.
        if (!bus.mem_busy) begin
          done = 1'b1;
        end else if (timeout_hit) begin
          done  = 1'b1;
          abort = 1'b1;
        end
      end
      S_RELEASE: begin
        // Memory must see start low on at least one negedge.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (done) begin
      rdata = abort ? ERR_WORD : bus.mem_q;
      if (grant_q == M_FETCH) begin
        f_q_d   = rdata;
        f_ack_d = 1'b1;
      end else begin
        d_q_d   = rdata;
        d_ack_d = 1'b1;
      end
      err_d        = abort;
      start_d      = 1'b0;
      last_grant_d = grant_q;
      state_d      = S_RELEASE;
    end
  end

  assign bus.mem_address = addr_q;
  assign bus.mem_data    = data_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_start   = start_q;
  assign bus.f_ack       = f_ack_q;
  assign bus.d_ack       = d_ack_q;
  assign bus.err         = err_q;
  assign bus.f_q         = f_q_q;
  assign bus.d_q         = d_q_q;
  assign state_o         = state_q;

endmodule
